nibble_serial_subtractor: RTL and testbench



---
 rtl/nibble_serial_subtractor.sv | 159 +++++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
// Sequential 16-bit subtractor computing d = a - b one nibble per clock,
// least-significant nibble first. A registered borrow links the nibbles and
// each nibble resolves its internal borrows with a 4-bit lookahead, so the
// critical path is a single nibble plus the borrow register.
//
// Ports:
//   clk   in   1  rising-edge clock
//   rst   in   1  synchronous, active-high reset
//   start in   1  request, sampled only in IDLE or DONE
//   a     in  16  minuend, latched on the accepting edge
//   b     in  16  subtrahend, latched on the accepting edge
//   busy  out  1  high while nibbles are being computed
//   done  out  1  one-cycle pulse, results valid from this cycle
//   d     out 16  a - b mod 2^16
//   bout  out  1  borrow out (a < b unsigned)
//   zero  out  1  d == 0
//   ovf   out  1  signed overflow of a - b
module nibble_serial_subtractor (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] d,
  output logic        bout,
  output logic        zero,
  output logic        ovf
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_work;
  logic        r_borrow;
  logic [1:0]  r_idx;
  logic [15:0] r_d;
  logic        r_bout;
  logic        r_zero;
  logic        r_ovf;

  logic        w_accept;
  logic [3:0]  w_na;
  logic [3:0]  w_nb;
  logic [3:0]  w_gen;
  logic [3:0]  w_prop;
  logic [4:0]  w_bor;
  logic [3:0]  w_ndiff;
  logic [15:0] w_work_next;

  // Select the active nibble of the latched operands.
  always_comb begin
    w_na = 4'h0;
    w_nb = 4'h0;
    unique case (r_idx)
      2'd0: begin w_na = r_a[3:0];   w_nb = r_b[3:0];   end
      2'd1: begin w_na = r_a[7:4];   w_nb = r_b[7:4];   end
      2'd2: begin w_na = r_a[11:8];  w_nb = r_b[11:8];  end
      2'd3: begin w_na = r_a[15:12]; w_nb = r_b[15:12]; end
      default: ;
    endcase
  end

  // Borrow lookahead: each borrow is a flat sum of products of gen/prop and
  // the nibble borrow-in, so no bit waits on the previous bit's borrow.
  always_comb begin
    w_gen    = ~w_na & w_nb;
    w_prop   = ~(w_na ^ w_nb);
    w_bor[0] = r_borrow;
    w_bor[1] = w_gen[0] | (w_prop[0] & r_borrow);
    w_bor[2] = w_gen[1] | (w_prop[1] & w_gen[0]) | (w_prop[1] & w_prop[0] & r_borrow);
    w_bor[3] = w_gen[2] | (w_prop[2] & w_gen[1]) | (w_prop[2] & w_prop[1] & w_gen[0])
             | (w_prop[2] & w_prop[1] & w_prop[0] & r_borrow);
    w_bor[4] = w_gen[3] | (w_prop[3] & w_gen[2]) | (w_prop[3] & w_prop[2] & w_gen[1])
             | (w_prop[3] & w_prop[2] & w_prop[1] & w_gen[0])
             | (w_prop[3] & w_prop[2] & w_prop[1] & w_prop[0] & r_borrow);
    w_ndiff  = w_na ^ w_nb ^ w_bor[3:0];
  end

  // Working difference with the current nibble merged in.
  always_comb begin
    w_work_next = r_work;
    unique case (r_idx)
      2'd0: w_work_next[3:0]   = w_ndiff;
      2'd1: w_work_next[7:4]   = w_ndiff;
      2'd2: w_work_next[11:8]  = w_ndiff;
      2'd3: w_work_next[15:12] = w_ndiff;
      default: ;
    endcase
  end

  assign w_accept = start && ((r_state == StIdle) || (r_state == StDone));

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) w_state_next = StRun;
      end
      StRun: begin
        busy = 1'b1;
        if (r_idx == 2'd3) w_state_next = StDone;
      end
      StDone: begin
        done         = 1'b1;
        w_state_next = start ? StRun : StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_a      <= 16'h0000;
      r_b      <= 16'h0000;
      r_work   <= 16'h0000;
      r_borrow <= 1'b0;
      r_idx    <= 2'd0;
      r_d      <= 16'h0000;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a      <= a;
        r_b      <= b;
        r_work   <= 16'h0000;
        r_borrow <= 1'b0;
        r_idx    <= 2'd0;
      end else if (r_state == StRun) begin
        r_work   <= w_work_next;
        r_borrow <= w_bor[4];
        r_idx    <= r_idx + 2'd1;
        // Last nibble: publish the complete result on the DONE-entry edge.
        if (r_idx == 2'd3) begin
          r_d    <= w_work_next;
          r_bout <= w_bor[4];
          r_zero <= (w_work_next == 16'h0000);
          r_ovf  <= (r_a[15] != r_b[15]) && (w_work_next[15] != r_a[15]);
        end
      end
    end
  end

  assign d    = r_d;
  assign bout = r_bout;
  assign zero = r_zero;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
module tb_nibble_serial_subtractor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] d;
  logic        bout;
  logic        zero;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  nibble_serial_subtractor dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .zero  (zero),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        bout;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic [15:0] ed,
                       input logic eb, input logic ez, input logic eo);
    int lat;
    int bc;
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(posedge clk); #1;  // E0
    start = 1'b0;
    a     = ~ta;
    b     = ta ^ 16'h5a5a;
    lat   = 0;
    bc    = 0;
    while (!done && lat < 10) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 4);
    chk("busy_cycles", bc, 4);
    chk("busy_in_done", {31'd0, busy}, 0);
    chk("d", {16'd0, d}, {16'd0, ed});
    chk("bout", {31'd0, bout}, {31'd0, eb});
    chk("zero", {31'd0, zero}, {31'd0, ez});
    chk("ovf", {31'd0, ovf}, {31'd0, eo});
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 0);
  endtask

  initial begin
    int          lat;
    int          nd;
    logic [15:0] cap;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [16:0] diff;

    tbl[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{16'hF0F0, 16'h0F0F, 16'hE1E1, 1'b0, 1'b0, 1'b0};

    rst   = 1'b1;
    start = 1'b1;  // reset must win over start
    a     = 16'h1234;
    b     = 16'h0001;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_d", {16'd0, d}, 0);
    chk("rst_bout", {31'd0, bout}, 0);
    chk("rst_zero", {31'd0, zero}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bout, tbl[i].zero, tbl[i].ovf);
    end

    // Operands and start toggled during RUN must not disturb the result.
    a     = 16'h5A5A;
    b     = 16'h1234;
    start = 1'b1;
    @(posedge clk); #1;  // E0
    a   = 16'hFFFF;
    b   = 16'h0000;
    nd  = 0;
    cap = 16'h0000;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c >= 3) start = 1'b0;
      else a = a - 16'h1111;
      if (done) begin
        nd++;
        cap = d;
      end
    end
    chk("robust_done_count", nd, 1);
    chk("robust_d", {16'd0, cap}, 32'h4826);

    // Back-to-back with start held through the DONE cycle.
    a     = 16'h0010;
    b     = 16'h0001;
    start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_lat1", lat, 4);
    chk("b2b_d1", {16'd0, d}, 32'h000F);
    chk("b2b_bout1", {31'd0, bout}, 0);
    a   = 16'h0005;
    b   = 16'h0007;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!done) chk("b2b_hold", {16'd0, d}, 32'h000F);
    end while (!done && lat < 10);
    start = 1'b0;
    chk("b2b_lat2", lat, 5);  // accept edge plus four nibble edges
    chk("b2b_d2", {16'd0, d}, 32'hFFFE);
    chk("b2b_bout2", {31'd0, bout}, 1);
    @(posedge clk); #1;
    chk("b2b_done_drop", {31'd0, done}, 0);

    // Reset sampled at E2 of an operation.
    a     = 16'h1111;
    b     = 16'h0001;
    start = 1'b1;
    @(posedge clk); #1;  // E0
    start = 1'b0;
    @(posedge clk); #1;  // E1
    rst = 1'b1;
    @(posedge clk); #1;  // E2
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    chk("mid_rst_d", {16'd0, d}, 0);
    chk("mid_rst_bout", {31'd0, bout}, 0);
    chk("mid_rst_zero", {31'd0, zero}, 0);
    chk("mid_rst_ovf", {31'd0, ovf}, 0);
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("mid_rst_no_done", nd, 0);
    do_op(16'h00FF, 16'h0100, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = (i % 17 == 0) ? ra : 16'($urandom);
      diff = {1'b0, ra} - {1'b0, rb};
      do_op(ra, rb, diff[15:0], ra < rb, ra == rb,
            (ra[15] != rb[15]) && (diff[15] != ra[15]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
